// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and counter sizing for the button conditioner
package button_pkg;

   typedef enum logic [1:0] {
      ST_LOW,
      ST_CHK_H,
      ST_HIGH,
      ST_CHK_L
   } btn_state_t;

   // Bits needed to hold 0..max_val inclusive, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// rtl/button_debounce_ch.sv - one channel: 2-FF sync, counter debounce, edge pulses
// Long-press hold counter built only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce_ch
   import button_pkg::*;
#(
   parameter int STABLE_CYCLES = 1000,
   parameter int LONG_CYCLES   = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic level_out,
   output logic pos_edge,
   output logic neg_edge,
   output logic long_press
);

   localparam int            CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam bit            ONE_SHOT = (STABLE_CYCLES == 1);

   logic          s1_q, s1_d, s2_q, s2_d;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          pos_q, pos_d, neg_q, neg_d;

   always_comb begin
      s1_d    = sig_in;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (s2_q) begin
               if (ONE_SHOT) begin
                  state_d = ST_HIGH;
                  level_d = 1'b1;
                  pos_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_CHK_H;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_CHK_H: begin
            if (!s2_q) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               level_d = 1'b1;
               pos_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HIGH: begin
            if (!s2_q) begin
               if (ONE_SHOT) begin
                  state_d = ST_LOW;
                  level_d = 1'b0;
                  neg_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_CHK_L;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_CHK_L: begin
            if (s2_q) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               level_d = 1'b0;
               neg_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
      end
   end

   assign level_out = level_q;
   assign pos_edge  = pos_q;
   assign neg_edge  = neg_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int            HW       = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Counts through a release glitch (ST_CHK_L) and saturates so each press fires once.
   always_comb begin
      hold_d = '0;
      if (state_q == ST_HIGH || state_q == ST_CHK_L) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
      end
      long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   logic unused_long_cfg;
   assign unused_long_cfg = (LONG_CYCLES > 0);
   assign long_press      = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_array.sv
// rtl/button_debounce_array.sv - N independent push-button conditioners
// Long-press output active only when DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce_array
   import button_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 1000,
   parameter int LONG_CYCLES   = 50000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sig_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] pos_edge,
   output logic [N_CH-1:0] neg_edge,
   output logic [N_CH-1:0] long_press
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_debounce_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .sig_in     (sig_in[i]),
         .level_out  (level_out[i]),
         .pos_edge   (pos_edge[i]),
         .neg_edge   (neg_edge[i]),
         .long_press (long_press[i])
      );
   end

endmodule
